// File: rtl/dm_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Holds the access-size encoding, the controller state encoding and the alignment rule.
// Imported by the controller top and by the lane-alignment sub-block.
package dm_ctrl_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_RD   = 3'd1,
    LD_CAP  = 3'd2,
    ST_WR   = 3'd3,
    RMW_RD  = 3'd4,
    RMW_CAP = 3'd5,
    RMW_WR  = 3'd6
  } dm_state_t;

  // Halfwords need an even address, words a 4-byte-aligned one; size 11 is never legal.
  function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] lane);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = |lane;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane alignment: load extract with sign/zero extension, and store merge into an old word.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the results are used.
module dm_lane_align
  import dm_ctrl_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [4:0]  byte_off;
  logic [4:0]  half_off;
  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  // Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
  assign byte_off   = {lane, 3'b000};
  assign half_off   = {lane[1], 4'b0000};
  assign byte_shift = old_word >> byte_off;
  assign half_shift = old_word >> half_off;
  assign byte_mask  = 32'h0000_00ff << byte_off;
  assign half_mask  = 32'h0000_ffff << half_off;

  // Select the lane for loads and splice the new lane into the old word for stores.
  always_comb begin
    ld_data = old_word;
    st_word = new_data;
    case (size)
      SZ_BYTE: begin
        ld_data = {{24{~is_unsigned & byte_shift[7]}}, byte_shift[7:0]};
        st_word = (old_word & ~byte_mask) | ((new_data & 32'h0000_00ff) << byte_off);
      end
      SZ_HALF: begin
        ld_data = {{16{~is_unsigned & half_shift[15]}}, half_shift[15:0]};
        st_word = (old_word & ~half_mask) | ((new_data & 32'h0000_ffff) << half_off);
      end
      default: begin
        ld_data = old_word;
        st_word = new_data;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage initiator turning byte/half/word loads and stores into word DM accesses.
// Latency: load 3 cycles, word store 2, sub-word store (read-modify-write) 4, misaligned 1.
// Backpressure: busy stalls the pipeline; req_valid is only sampled while busy is low.
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DM_AW  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              DM_read,
  output logic              DM_write,
  output logic [DM_AW-1:0]  DM_addr,
  output logic [DATA_W-1:0] DM_in,
  input  logic [DATA_W-1:0] DM_out
);

  dm_state_t         state_q, state_d;
  mem_size_t         size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              uns_q, uns_d;
  logic [DM_AW-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;

  mem_size_t         req_sz;
  logic              accept;
  logic              req_bad;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_word;
  logic              unused_addr_hi;

  assign req_sz  = mem_size_t'(req_size);
  assign accept  = (state_q == IDLE) && req_valid;
  assign req_bad = is_misaligned(req_sz, req_addr[1:0]);

  // Address bits above the DM window wrap, so they are deliberately dropped.
  assign unused_addr_hi = ^req_addr[31:DM_AW+2];

  dm_lane_align u_align (
    .size        (size_q),
    .lane        (lane_q),
    .is_unsigned (uns_q),
    .old_word    (DM_out),
    .new_data    (din_q),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  // State and datapath registers; reset drops any in-flight request silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      size_q      <= SZ_BYTE;
      lane_q      <= '0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next state: sub-word stores detour through read and capture before writing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !req_bad) begin
          if (!req_write)             state_d = LD_RD;
          else if (req_sz == SZ_WORD) state_d = ST_WR;
          else                        state_d = RMW_RD;
        end
      end
      LD_RD:   state_d = LD_CAP;
      LD_CAP:  state_d = IDLE;
      ST_WR:   state_d = IDLE;
      RMW_RD:  state_d = RMW_CAP;
      RMW_CAP: state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates and the single-cycle response; din_q carries store data until merge.
  always_comb begin
    size_d      = size_q;
    lane_d      = lane_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          size_d = req_sz;
          lane_d = req_addr[1:0];
          uns_d  = req_unsigned;
          addr_d = req_addr[DM_AW+1:2];
          if (req_write) din_d = req_wdata;
          if (req_bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      LD_CAP: begin
        rdata_d     = ld_data;
        rsp_valid_d = 1'b1;
      end
      RMW_CAP: din_d = st_word;
      ST_WR,
      RMW_WR:  rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  // DM strobes are gated by reset so an interrupted sequence never writes a partial word.
  always_comb begin
    busy      = (state_q != IDLE);
    DM_read   = rst && ((state_q == LD_RD) || (state_q == RMW_RD));
    DM_write  = rst && ((state_q == ST_WR) || (state_q == RMW_WR));
    DM_addr   = addr_q;
    DM_in     = din_q;
    rsp_valid = rsp_valid_q;
    rsp_err   = rsp_err_q;
    rsp_rdata = rdata_q;
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl with a registered word memory and a byte-level reference.
// Latency: responses are matched in order against a queue filled at acceptance.
// Backpressure: the driver holds req_valid until the DUT is not busy.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, rsp_valid, rsp_err, DM_read, DM_write;
  logic [31:0] rsp_rdata, DM_in;
  logic [31:0] dm_out = '0;
  logic [11:0] DM_addr;

  dm_access_ctrl #(.DATA_W(32), .DM_AW(12)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .DM_read(DM_read), .DM_write(DM_write),
    .DM_addr(DM_addr), .DM_in(DM_in), .DM_out(dm_out)
  );

  always #5 clk = ~clk;

  // Registered word memory behind the DM port.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (DM_write) mem[DM_addr] <= DM_in;
    if (DM_read)  dm_out <= mem[DM_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Byte-level reference image of the DM (14 address bits = 4096 words).
  logic [7:0] rmem [0:16383];
  initial for (int i = 0; i < 16384; i++) rmem[i] = 8'h00;

  typedef struct {
    logic        err;
    logic        ld;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int issued = 0, responses = 0;
  int acc_cyc = 0;
  int dm_rd_cnt = 0, dm_wr_cnt = 0;
  int last_wr_cyc = 0;
  logic [11:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  // Response monitor, DM activity log and read/write exclusivity check.
  always @(negedge clk) begin
    exp_t e;
    if (DM_read && DM_write) chk("dm_rd_wr_excl", {DM_read, DM_write}, 2'b01);
    if (DM_read) dm_rd_cnt++;
    if (DM_write) begin
      dm_wr_cnt++;
      last_wr_cyc  = cyc;
      last_wr_addr = DM_addr;
      last_wr_data = DM_in;
    end
    if (rsp_valid) begin
      responses++;
      if (sb.size() == 0) begin
        chk("rsp_expected", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_latency", cyc - e.acc, e.lat);
        if (e.ld && !e.err) chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    int b;
    logic [31:0] v;
    b = int'(a[13:0]);
    v = '0;
    if (sz == 2'b00)      v = uns ? {24'h0, rmem[b]} : {{24{rmem[b][7]}}, rmem[b]};
    else if (sz == 2'b01) v = uns ? {16'h0, rmem[b+1], rmem[b]}
                                  : {{16{rmem[b+1][7]}}, rmem[b+1], rmem[b]};
    else                  v = {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
    return v;
  endfunction

  // Drive one request, hold it until accepted, then record the expected response.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   b;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    if (busy) begin
      chk("accept_timeout", busy, 1'b0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc = cyc;
    issued++;
    b = int'(a[13:0]);
    e.err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    e.ld  = !wr;
    e.acc = acc_cyc;
    e.rdata = '0;
    if (e.err)              e.lat = 0;
    else if (!wr)           e.lat = 2;
    else if (sz == 2'b10)   e.lat = 1;
    else                    e.lat = 3;
    if (!e.err && !wr) e.rdata = ref_load(a, sz, uns);
    if (!e.err && wr) begin
      rmem[b] = wd[7:0];
      if (sz != 2'b00) rmem[b+1] = wd[15:8];
      if (sz == 2'b10) begin
        rmem[b+2] = wd[23:16];
        rmem[b+3] = wd[31:24];
      end
    end
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (sb.size() != 0 || busy); k++) @(negedge clk);
    chk("drain_pending", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int rd0, wr0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_dm_addr", DM_addr, 0);
    chk("rst_dm_in", DM_in, 0);
    chk("rst_dm_strobes", {DM_read, DM_write}, 0);
    rst = 1'b1;

    // Word store then word load.
    issue(1, 2'b10, 0, 32'h40, 32'hDEADBEEF);
    drain();
    chk("wst_addr", last_wr_addr, 12'h010);
    chk("wst_data", last_wr_data, 32'hDEADBEEF);
    chk("wst_t1", last_wr_cyc - acc_cyc, 0);
    issue(0, 2'b10, 0, 32'h40, 0);
    drain();
    chk("wld_data", rsp_rdata, 32'hDEADBEEF);

    // Byte read-modify-write.
    issue(1, 2'b10, 0, 32'h40, 32'h11223344);
    issue(1, 2'b00, 0, 32'h41, 32'h0000005A);
    drain();
    chk("rmw_addr", last_wr_addr, 12'h010);
    chk("rmw_data", last_wr_data, 32'h11225A44);
    chk("rmw_t3", last_wr_cyc - acc_cyc, 2);
    issue(0, 2'b10, 0, 32'h40, 0);
    drain();
    chk("rmw_readback", rsp_rdata, 32'h11225A44);

    // Sign and zero extension.
    issue(1, 2'b10, 0, 32'h40, 32'h80FF0000);
    issue(0, 2'b00, 0, 32'h43, 0);
    drain();
    chk("lb_signed", rsp_rdata, 32'hFFFFFF80);
    issue(0, 2'b00, 1, 32'h43, 0);
    drain();
    chk("lb_unsigned", rsp_rdata, 32'h00000080);
    issue(0, 2'b01, 0, 32'h42, 0);
    drain();
    chk("lh_signed", rsp_rdata, 32'hFFFF80FF);
    issue(0, 2'b10, 0, 32'hFFFFC040, 0);
    drain();
    chk("addr_wrap", rsp_rdata, 32'h80FF0000);

    // Misaligned and illegal: error response, no DM traffic, never busy.
    rd0 = dm_rd_cnt; wr0 = dm_wr_cnt;
    issue(0, 2'b10, 0, 32'h42, 0);
    @(negedge clk);
    chk("err_busy_word", busy, 0);
    issue(1, 2'b11, 0, 32'h40, 32'h12345678);
    @(negedge clk);
    chk("err_busy_ill", busy, 0);
    issue(1, 2'b01, 0, 32'h41, 32'h1234);
    drain();
    chk("err_no_read", dm_rd_cnt - rd0, 0);
    chk("err_no_write", dm_wr_cnt - wr0, 0);

    // Back-to-back mix, each new request held while busy.
    issue(0, 2'b10, 0, 32'h40, 0);
    issue(1, 2'b01, 0, 32'h46, 32'hABCD);
    issue(0, 2'b01, 1, 32'h46, 0);
    issue(1, 2'b00, 0, 32'h47, 32'h00000099);
    issue(0, 2'b10, 0, 32'h44, 0);
    issue(0, 2'b00, 0, 32'h45, 0);
    drain();

    // Random traffic over a zeroed window.
    for (int i = 0; i < 8; i++) issue(1, 2'b10, 0, 32'h100 + 32'(4 * i), 0);
    for (int i = 0; i < 40; i++)
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'h100 + 32'($urandom_range(0, 31)), $urandom);
    drain();

    // Reset while in RMW_CAP: no write, outputs cleared, memory unchanged.
    issue(1, 2'b10, 0, 32'h80, 32'hCAFEF00D);
    drain();
    wr0 = dm_wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h81; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_before_rst", DM_read, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp", {rsp_valid, rsp_err}, 0);
    chk("midrst_rdata", rsp_rdata, 0);
    chk("midrst_dm_addr", DM_addr, 0);
    chk("midrst_dm_in", DM_in, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_no_write", dm_wr_cnt - wr0, 0);
    issue(0, 2'b10, 0, 32'h80, 0);
    drain();
    chk("midrst_mem_kept", rsp_rdata, 32'hCAFEF00D);
    chk("rsp_count", responses, issued);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Pipeline-side initiator for the word-organised data memory, sitting in the MEM stage between execute results and the DM port.
- Converts byte, halfword and word load/store requests into DM_read/DM_write word accesses.
- Sub-word stores use read-modify-write; loads are extracted from the byte lane and sign- or zero-extended.
- Provides a stall (busy) and a single-cycle response pulse to the pipeline.

Parameters:
DATA_W, 32, data/register width (fixed 32; byte lanes assume 4 bytes)
DM_AW, 12, DM word-address width; DM_addr = req_addr[DM_AW+1:2]

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
req_valid  in  1  request strobe, sampled only when busy=0
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
req_addr  in  32  byte address
req_wdata  in  DATA_W  store data, right-justified
busy  out  1  controller occupied; pipeline stalls and holds request
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  with rsp_valid: misaligned/illegal, no DM access made
rsp_rdata  out  DATA_W  formatted load data, valid with rsp_valid on loads
DM_read  out  1  DM read enable
DM_write  out  1  DM write enable
DM_addr  out  DM_AW  DM word address
DM_in  out  DATA_W  DM write data
DM_out  in  DATA_W  DM read data, registered, valid the cycle after DM_read

Behaviour:
- rst=0 at a clk edge: state IDLE; busy, rsp_valid, rsp_err, rsp_rdata, DM_addr, DM_in all 0. DM_read/DM_write are combinationally gated to 0 while rst=0, so a reset mid-operation never issues a partial write. Any in-flight request is discarded with no response.
- States: IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_CAP, RMW_WR.
- busy = (state != IDLE).
- DM_read = LD_RD or RMW_RD. DM_write = ST_WR or RMW_WR. The two are never high together.
- DM_addr and DM_in come from registers captured at acceptance or RMW_CAP.
- Accept: IDLE and req_valid=1. The request is latched and rsp_valid/rsp_err clear.
- Misaligned conditions: half with addr[0]=1, word with addr[1:0]!=0, or size=11. The next cycle gives rsp_valid=1, rsp_err=1; state stays IDLE; no DM access.
- Load: accept (T0) -> LD_RD (T1, DM_read=1) -> LD_CAP (T2, DM_out valid, format into rsp_rdata) -> IDLE with rsp_valid=1 (T3).
- Word store: T0 accept -> ST_WR (T1, DM_write=1, DM_in=wdata) -> IDLE with rsp_valid=1 (T2).
- Byte/half store: RMW_RD (T1) -> RMW_CAP (T2, merge new lane(s) into DM_out) -> RMW_WR (T3, DM_write=1) -> IDLE with rsp_valid=1 (T4).
- Lanes are little-endian: byte lane = addr[1:0]; half lane = addr[1] (bits 15:0 or 31:16). Untouched lanes are written back unchanged.
- rsp_rdata holds its value until the next load completes. rsp_valid is exactly one cycle.
- A new request can be accepted in the same cycle rsp_valid is high (back-to-back). req_valid while busy is ignored.
- Address bits above DM_AW+1 are ignored (wrap modulo DM size).

Decomposition:
- Package dm_ctrl_pkg: mem_size_t (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL), dm_state_t, constant WORD_BYTES=4.
- Sub-module dm_lane_align (combinational): load extract plus sign/zero extend, and store merge from (size, addr[1:0], old word, new data).

Test Plan:
- Word store 0xDEADBEEF @0x40, then word load @0x40 -> DM_write at T1 with DM_addr=0x10; load rsp_valid at T3 with rsp_rdata=0xDEADBEEF.
- Byte store 0x5A @0x41 over 0x11223344 -> RMW sequence with DM_write at T3, DM_in=0x11225A44; word load returns 0x11225A44.
- Byte load @0x43 of 0x80FF0000: signed -> 0xFFFFFF80, unsigned -> 0x00000080. Half load @0x42 signed -> 0xFFFF80FF.
- Word load @0x42 and size=11 -> rsp_err=1 next cycle; DM_read/DM_write never asserted; busy stays 0.
- Back-to-back: store accepted in the cycle the previous load's rsp_valid=1 -> no lost or duplicated rsp_valid, ordering preserved. req_valid held during busy accepted exactly once.
- Assert rst=0 during RMW_CAP -> DM_write never asserts; all outputs 0 after the edge; memory word unchanged on read-back.
